fft_stage_sched: RTL and testbench

//  Sequences the radix-2 butterfly datapath for an in-place N-point DIT FFT.

---
 rtl/fft_stage_sched.sv | 190 +++++++++++++++++++
 tb/tb_fft_stage_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sched.sv
// fft_stage_sched
//   Address and strobe sequencer for an in-place radix-2 DIT FFT whose input
//   samples are already stored in bit-reversed order. One butterfly is issued
//   per cycle. Each stage issues N/2 reads, then idles for D = RAM_LATENCY +
//   BF_LATENCY cycles so that the last write of the stage lands before the
//   first read of the next stage.
//
// Ports
//   aclk      clock, rising edge
//   areset    synchronous reset, active-high
//   start     one-cycle run request, honoured only when idle
//   busy      high from the cycle after an accepted start through the done cycle
//   done      one-cycle pulse after the final write of the last stage
//   stage     current stage index
//   rd_en     read strobe for the sample RAM and twiddle ROM
//   rd_addr0  upper butterfly input address
//   rd_addr1  lower butterfly input address
//   tw_addr   twiddle ROM address (exponent of W_N)
//   bf_valid  butterfly inputs valid this cycle (rd_en delayed RAM_LATENCY)
//   wr_en     write strobe (rd_en delayed D)
//   wr_addr0  write-back address for the upper butterfly output
//   wr_addr1  write-back address for the lower butterfly output
module fft_stage_sched #(
    parameter int LOG2N       = 6,
    parameter int BF_LATENCY  = 4,
    parameter int RAM_LATENCY = 1
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr0,
    output logic [LOG2N-1:0] rd_addr1,
    output logic [LOG2N-2:0] tw_addr,
    output logic             bf_valid,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr0,
    output logic [LOG2N-1:0] wr_addr1
);

    localparam int D  = RAM_LATENCY + BF_LATENCY;
    localparam int KW = LOG2N - 1;
    localparam int CW = $clog2(D + 1);

    localparam logic [KW-1:0]    K_LAST = '1;
    localparam logic [CW-1:0]    C_LAST = CW'(D - 1);
    localparam logic [3:0]       S_LAST = 4'(LOG2N - 1);
    localparam logic [3:0]       TW_SH  = 4'(KW);
    localparam logic [LOG2N-1:0] ONE_A  = LOG2N'(1);
    localparam logic [KW-1:0]    ONE_K  = KW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [KW-1:0] k, k_n;
    logic [3:0]    s, s_n;
    logic [CW-1:0] cnt, cnt_n;

    // Upper input address: butterfly index k with a zero inserted at bit s.
    function automatic logic [LOG2N-1:0] lo_addr(input logic [KW-1:0] kk,
                                                 input logic [3:0]    ss);
        logic [LOG2N-1:0] kx;
        logic [LOG2N-1:0] mask;
        kx   = {1'b0, kk};
        mask = (ONE_A << ss) - ONE_A;
        return ((kx >> ss) << (ss + 4'd1)) | (kx & mask);
    endfunction

    // Twiddle exponent: position inside the group, scaled to the N-point ROM.
    function automatic logic [KW-1:0] tw_calc(input logic [KW-1:0] kk,
                                              input logic [3:0]    ss);
        logic [KW-1:0] mask;
        mask = (ONE_K << ss) - ONE_K;
        return (kk & mask) << (TW_SH - ss);
    endfunction

    always_comb begin
        state_n = state;
        k_n     = k;
        s_n     = s;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                k_n = '0;
                s_n = '0;
                if (start) state_n = RUN;
            end
            RUN: begin
                if (k == K_LAST) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == C_LAST) begin
                    k_n = '0;
                    if (s == S_LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        s_n     = s + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                s_n     = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    logic [LOG2N-1:0] a0_n;
    assign a0_n = lo_addr(k_n, s_n);

    // Outputs are registered from next-state values so they line up with
    // the FSM state of the same cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= IDLE;
            k        <= '0;
            s        <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            stage    <= '0;
            rd_en    <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            tw_addr  <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            s     <= s_n;
            cnt   <= cnt_n;
            busy  <= (state_n != IDLE);
            done  <= (state_n == DONE);
            stage <= s_n;
            rd_en <= (state_n == RUN);
            if (state_n == RUN) begin
                rd_addr0 <= a0_n;
                rd_addr1 <= a0_n + (ONE_A << s_n);
                tw_addr  <= tw_calc(k_n, s_n);
            end
        end
    end

    // Issue-to-writeback delay line; cleared on reset so an aborted run
    // leaves no pending writes behind.
    logic             vld_pipe [D];
    logic [LOG2N-1:0] a0_pipe  [D];
    logic [LOG2N-1:0] a1_pipe  [D];

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < D; i++) begin
                vld_pipe[i] <= 1'b0;
                a0_pipe[i]  <= '0;
                a1_pipe[i]  <= '0;
            end
        end else begin
            vld_pipe[0] <= rd_en;
            a0_pipe[0]  <= rd_addr0;
            a1_pipe[0]  <= rd_addr1;
            for (int i = 1; i < D; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a0_pipe[i]  <= a0_pipe[i-1];
                a1_pipe[i]  <= a1_pipe[i-1];
            end
        end
    end

    assign bf_valid = vld_pipe[RAM_LATENCY-1];
    assign wr_en    = vld_pipe[D-1];
    assign wr_addr0 = a0_pipe[D-1];
    assign wr_addr1 = a1_pipe[D-1];

endmodule

// File: tb/tb_fft_stage_sched.sv
module tb_fft_stage_sched;

    localparam int SL2N = 3;
    localparam int SBF  = 2;
    localparam int SRL  = 1;
    localparam int SD   = SRL + SBF;
    localparam int SN   = 1 << SL2N;
    localparam int SSL  = SN / 2 + SD;
    localparam int STOT = 1 + SL2N * SSL;

    localparam int BL2N = 6;
    localparam int BBF  = 4;
    localparam int BRL  = 1;
    localparam int BN   = 1 << BL2N;
    localparam int BTOT = 1 + BL2N * (BN / 2 + BRL + BBF);
    localparam real PI  = 3.14159265358979323846;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_rst, s_start, s_busy, s_done, s_rd_en, s_bf_valid, s_wr_en;
    logic [3:0] s_stage;
    logic [2:0] s_rd_addr0, s_rd_addr1, s_wr_addr0, s_wr_addr1;
    logic [1:0] s_tw;

    logic       b_rst, b_start, b_busy, b_done, b_rd_en, b_bf_valid, b_wr_en;
    logic [3:0] b_stage;
    logic [5:0] b_rd_addr0, b_rd_addr1, b_wr_addr0, b_wr_addr1;
    logic [4:0] b_tw;

    fft_stage_sched #(.LOG2N(SL2N), .BF_LATENCY(SBF), .RAM_LATENCY(SRL)) u_small (
        .aclk(clk), .areset(s_rst), .start(s_start), .busy(s_busy), .done(s_done),
        .stage(s_stage), .rd_en(s_rd_en), .rd_addr0(s_rd_addr0), .rd_addr1(s_rd_addr1),
        .tw_addr(s_tw), .bf_valid(s_bf_valid), .wr_en(s_wr_en),
        .wr_addr0(s_wr_addr0), .wr_addr1(s_wr_addr1)
    );

    fft_stage_sched #(.LOG2N(BL2N), .BF_LATENCY(BBF), .RAM_LATENCY(BRL)) u_big (
        .aclk(clk), .areset(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
        .stage(b_stage), .rd_en(b_rd_en), .rd_addr0(b_rd_addr0), .rd_addr1(b_rd_addr1),
        .tw_addr(b_tw), .bf_valid(b_bf_valid), .wr_en(b_wr_en),
        .wr_addr0(b_wr_addr0), .wr_addr1(b_wr_addr1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference butterfly list for the small config, straight from the
    // textbook stage/group/position loops.
    int ea0[$], ea1[$], etw[$];

    task automatic build_small();
        for (int s = 0; s < SL2N; s++) begin
            int half;
            half = 1 << s;
            for (int g = 0; g < SN / (2 * half); g++)
                for (int p = 0; p < half; p++) begin
                    ea0.push_back(g * 2 * half + p);
                    ea1.push_back(g * 2 * half + p + half);
                    etw.push_back(p * (SN / (2 * half)));
                end
        end
    endtask

    // Cycle c (c=0 is the start cycle) carries a read iff it falls in the
    // first N/2 cycles of one of the LOG2N stage windows.
    function automatic bit rd_exp(input int c);
        int st, t;
        if (c < 1) return 1'b0;
        st = (c - 1) / SSL;
        t  = (c - 1) % SSL;
        return (st < SL2N) && (t < SN / 2);
    endfunction

    task automatic run_small(input int p1, input int p2, input string tag);
        int ri, wi, ndone, est;
        ri = 0; wi = 0; ndone = 0;
        s_start = 1'b1;
        step();
        for (int c = 1; c <= STOT; c++) begin
            s_start = (c == p1) || (c == p2);
            check({tag, "_rd_en"}, s_rd_en, rd_exp(c));
            check({tag, "_bf_valid"}, s_bf_valid, rd_exp(c - SRL));
            check({tag, "_wr_en"}, s_wr_en, rd_exp(c - SD));
            check({tag, "_busy"}, s_busy, 1);
            check({tag, "_done"}, s_done, (c == STOT));
            est = (c - 1) / SSL;
            if (est > SL2N - 1) est = SL2N - 1;
            check({tag, "_stage"}, s_stage, est);
            if (rd_exp(c)) begin
                check({tag, "_rd_addr0"}, s_rd_addr0, ea0[ri]);
                check({tag, "_rd_addr1"}, s_rd_addr1, ea1[ri]);
                check({tag, "_tw_addr"}, s_tw, etw[ri]);
                ri++;
            end
            if (rd_exp(c - SD)) begin
                check({tag, "_wr_addr0"}, s_wr_addr0, ea0[wi]);
                check({tag, "_wr_addr1"}, s_wr_addr1, ea1[wi]);
                wi++;
            end
            if (s_done) ndone++;
            step();
        end
        s_start = 1'b0;
        check({tag, "_done_count"}, ndone, 1);
    endtask

    task automatic idle_small(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, s_busy, 0);
            check({tag, "_rd_en"}, s_rd_en, 0);
            check({tag, "_wr_en"}, s_wr_en, 0);
            check({tag, "_done"}, s_done, 0);
            check({tag, "_stage"}, s_stage, 0);
            step();
        end
    endtask

    task automatic reset_mid(input string tag);
        int r;
        r = int'($urandom_range(2, STOT - 3));
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int c = 1; c < r; c++) step();
        s_rst = 1'b1;
        step();
        check({tag, "_busy"}, s_busy, 0);
        check({tag, "_rd_en"}, s_rd_en, 0);
        check({tag, "_wr_en"}, s_wr_en, 0);
        check({tag, "_wr_addr0"}, s_wr_addr0, 0);
        step();
        s_start = 1'b1;
        step();
        s_rst   = 1'b0;
        s_start = 1'b0;
        for (int i = 0; i < SD + 2; i++) begin
            check({tag, "_post_wr_en"}, s_wr_en, 0);
            check({tag, "_post_busy"}, s_busy, 0);
            check({tag, "_post_rd_en"}, s_rd_en, 0);
            step();
        end
    endtask

    // Big config: sample RAM plus a behavioural butterfly whose results
    // travel in a FIFO and are written wherever wr_en/wr_addr point.
    real ram_re[BN], ram_im[BN];
    real xr[BN], xi[BN];
    real q0r[$], q0i[$], q1r[$], q1i[$];

    function automatic int bitrev6(input int v);
        int r;
        r = 0;
        for (int i = 0; i < BL2N; i++) r |= ((v >> i) & 1) << (BL2N - 1 - i);
        return r;
    endfunction

    function automatic real fabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    task automatic run_big(input string tag);
        bit got_done;
        int done_cyc;
        real ar, ai, br, bi, wr, wi, tr, ti, ang;
        for (int n = 0; n < BN; n++) begin
            ram_re[bitrev6(n)] = xr[n];
            ram_im[bitrev6(n)] = xi[n];
        end
        got_done = 1'b0;
        done_cyc = 0;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int c = 1; c <= 3000 && !got_done; c++) begin
            if (b_wr_en) begin
                if (q0r.size() == 0) begin
                    check({tag, "_fifo_underflow"}, 0, 1);
                end else begin
                    ram_re[b_wr_addr0] = q0r.pop_front();
                    ram_im[b_wr_addr0] = q0i.pop_front();
                    ram_re[b_wr_addr1] = q1r.pop_front();
                    ram_im[b_wr_addr1] = q1i.pop_front();
                end
            end
            if (b_rd_en) begin
                ar  = ram_re[b_rd_addr0]; ai = ram_im[b_rd_addr0];
                br  = ram_re[b_rd_addr1]; bi = ram_im[b_rd_addr1];
                ang = 2.0 * PI * real'(b_tw) / real'(BN);
                wr  = $cos(ang);
                wi  = -$sin(ang);
                tr  = wr * br - wi * bi;
                ti  = wr * bi + wi * br;
                q0r.push_back(ar + tr); q0i.push_back(ai + ti);
                q1r.push_back(ar - tr); q1i.push_back(ai - ti);
            end
            if (b_done) begin
                got_done = 1'b1;
                done_cyc = c;
            end
            step();
        end
        check({tag, "_done_seen"}, got_done, 1);
        check({tag, "_done_cycle"}, done_cyc, BTOT);
        check({tag, "_fifo_empty"}, q0r.size(), 0);
    endtask

    task automatic check_dft(input string tag);
        real sr, si, ang;
        bit ok;
        for (int kk = 0; kk < BN; kk++) begin
            sr = 0.0; si = 0.0;
            for (int n = 0; n < BN; n++) begin
                ang = -2.0 * PI * real'(kk * n) / real'(BN);
                sr += xr[n] * $cos(ang) - xi[n] * $sin(ang);
                si += xr[n] * $sin(ang) + xi[n] * $cos(ang);
            end
            ok = (fabs(sr - ram_re[kk]) < 1e-6) && (fabs(si - ram_im[kk]) < 1e-6);
            check({tag, "_dft_bin"}, ok, 1);
        end
    endtask

    initial begin
        bit ok;
        real mag;
        s_rst = 1'b1; s_start = 1'b0;
        b_rst = 1'b1; b_start = 1'b0;
        build_small();
        step(); step(); step();
        check("rst_busy", s_busy, 0);
        check("rst_done", s_done, 0);
        check("rst_rd_en", s_rd_en, 0);
        check("rst_bf_valid", s_bf_valid, 0);
        check("rst_wr_en", s_wr_en, 0);
        check("rst_stage", s_stage, 0);
        check("rst_rd_addr0", s_rd_addr0, 0);
        check("rst_rd_addr1", s_rd_addr1, 0);
        check("rst_tw_addr", s_tw, 0);
        check("rst_wr_addr1", s_wr_addr1, 0);
        s_rst = 1'b0;
        b_rst = 1'b0;
        step();
        idle_small(2, "idle0");

        run_small(-1, -1, "seq");
        idle_small(2, "seq_idle");

        run_small(5, 20, "start_busy");
        idle_small(2, "start_busy_idle");
        for (int i = 0; i < 3; i++) begin
            run_small(int'($urandom_range(1, STOT)), int'($urandom_range(1, STOT)), "start_rand");
            idle_small(int'($urandom_range(1, 3)), "start_rand_idle");
        end

        run_small(-1, -1, "b2b_first");
        run_small(-1, -1, "b2b_second");
        idle_small(2, "b2b_idle");

        for (int i = 0; i < 2; i++) begin
            reset_mid("rst_mid");
            run_small(-1, -1, "rst_recover");
            idle_small(1, "rst_recover_idle");
        end

        // Impulse: every bin is 1+0j.
        for (int n = 0; n < BN; n++) begin
            xr[n] = (n == 0) ? 1.0 : 0.0;
            xi[n] = 0.0;
        end
        run_big("impulse");
        for (int kk = 0; kk < BN; kk++) begin
            ok = (fabs(ram_re[kk] - 1.0) < 1e-9) && (fabs(ram_im[kk]) < 1e-9);
            check("impulse_bin", ok, 1);
        end

        // Cosine at bin 5: energy only in bins 5 and 59.
        for (int n = 0; n < BN; n++) begin
            xr[n] = $cos(2.0 * PI * 5.0 * real'(n) / real'(BN));
            xi[n] = 0.0;
        end
        run_big("cosine");
        for (int kk = 0; kk < BN; kk++) begin
            mag = ram_re[kk] * ram_re[kk] + ram_im[kk] * ram_im[kk];
            check("cosine_peak", (mag > 256.0), (kk == 5) || (kk == BN - 5));
        end

        // Random complex vector against a direct DFT.
        for (int n = 0; n < BN; n++) begin
            xr[n] = real'(int'($urandom_range(0, 2000)) - 1000) / 1000.0;
            xi[n] = real'(int'($urandom_range(0, 2000)) - 1000) / 1000.0;
        end
        run_big("random");
        check_dft("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
